// File: rtl/tmds_encoder_pipe.sv
// Pipelined DVI TMDS 8b/10b channel encoder: popcount, transition minimisation,
// DC balance, then an output register. Inputs sampled at edge N reach dout after edge N+3.
module tmds_encoder_pipe (
    input  logic       pclk,
    input  logic       reset,
    input  logic [7:0] din,
    input  logic       c0,
    input  logic       c1,
    input  logic       de,
    output logic [9:0] dout
);

    localparam logic [9:0] TOKEN_00 = 10'b1101010100;
    localparam logic [9:0] TOKEN_01 = 10'b0010101011;
    localparam logic [9:0] TOKEN_10 = 10'b0101010100;
    localparam logic [9:0] TOKEN_11 = 10'b1010101011;

    // Stage 1: registered inputs and popcount of din
    logic [7:0] s1_din_q, s1_din_d;
    logic [3:0] s1_n1d_q, s1_n1d_d;
    logic       s1_c0_q, s1_c0_d;
    logic       s1_c1_q, s1_c1_d;
    logic       s1_de_q, s1_de_d;

    // Stage 2: transition-minimised word and its ones/zeros counts
    logic [8:0] s2_qm_q, s2_qm_d;
    logic [3:0] s2_n1q_q, s2_n1q_d;
    logic [3:0] s2_n0q_q, s2_n0q_d;
    logic       s2_c0_q, s2_c0_d;
    logic       s2_c1_q, s2_c1_d;
    logic       s2_de_q, s2_de_d;

    // Stage 3: balanced symbol and running disparity, then the output register
    logic [9:0]        s3_sym_q, s3_sym_d;
    logic signed [4:0] cnt_q, cnt_d;
    logic [9:0]        dout_q, dout_d;

    always_comb begin
        s1_din_d = din;
        s1_c0_d  = c0;
        s1_c1_d  = c1;
        s1_de_d  = de;
        s1_n1d_d = '0;
        for (int i = 0; i < 8; i++) begin
            s1_n1d_d = s1_n1d_d + {3'b000, din[i]};
        end
    end

    always_comb begin
        logic       use_xnor;
        logic [8:0] qm;
        logic [3:0] n1;
        use_xnor = (s1_n1d_q > 4'd4) || ((s1_n1d_q == 4'd4) && !s1_din_q[0]);
        qm       = '0;
        qm[0]    = s1_din_q[0];
        for (int i = 1; i < 8; i++) begin
            qm[i] = use_xnor ? ~(qm[i-1] ^ s1_din_q[i]) : (qm[i-1] ^ s1_din_q[i]);
        end
        qm[8] = ~use_xnor;
        n1    = '0;
        for (int i = 0; i < 8; i++) begin
            n1 = n1 + {3'b000, qm[i]};
        end
        s2_qm_d  = qm;
        s2_n1q_d = n1;
        s2_n0q_d = 4'd8 - n1;
        s2_c0_d  = s1_c0_q;
        s2_c1_d  = s1_c1_q;
        s2_de_d  = s1_de_q;
    end

    // NOTE: every output of this block gets a default first so no path leaves it unassigned (no latch).
    always_comb begin
        logic signed [4:0] n1s, n0s, disp, two_qm8, two_nqm8;
        logic              qm8;
        qm8      = s2_qm_q[8];
        n1s      = {1'b0, s2_n1q_q};
        n0s      = {1'b0, s2_n0q_q};
        disp     = n1s - n0s;
        two_qm8  = {3'b000, qm8, 1'b0};
        two_nqm8 = {3'b000, ~qm8, 1'b0};
        s3_sym_d = TOKEN_00;
        cnt_d    = cnt_q;
        if (!s2_de_q) begin
            cnt_d = '0;
            case ({s2_c1_q, s2_c0_q})
                2'b00:   s3_sym_d = TOKEN_00;
                2'b01:   s3_sym_d = TOKEN_01;
                2'b10:   s3_sym_d = TOKEN_10;
                default: s3_sym_d = TOKEN_11;
            endcase
        end else if ((cnt_q == 5'sd0) || (s2_n1q_q == s2_n0q_q)) begin
            s3_sym_d = {~qm8, qm8, qm8 ? s2_qm_q[7:0] : ~s2_qm_q[7:0]};
            cnt_d    = qm8 ? (cnt_q + disp) : (cnt_q - disp);
        end else if (((cnt_q > 5'sd0) && (s2_n1q_q > s2_n0q_q)) ||
                     ((cnt_q < 5'sd0) && (s2_n0q_q > s2_n1q_q))) begin
            s3_sym_d = {1'b1, qm8, ~s2_qm_q[7:0]};
            cnt_d    = cnt_q + two_qm8 - disp;
        end else begin
            s3_sym_d = {1'b0, qm8, s2_qm_q[7:0]};
            cnt_d    = cnt_q - two_nqm8 + disp;
        end
        dout_d = s3_sym_q;
    end

    // NOTE: state updates use non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge pclk) begin
        if (reset) begin
            s1_din_q <= '0;
            s1_n1d_q <= '0;
            s1_c0_q  <= 1'b0;
            s1_c1_q  <= 1'b0;
            s1_de_q  <= 1'b0;
            s2_qm_q  <= '0;
            s2_n1q_q <= '0;
            s2_n0q_q <= '0;
            s2_c0_q  <= 1'b0;
            s2_c1_q  <= 1'b0;
            s2_de_q  <= 1'b0;
            s3_sym_q <= '0;
            cnt_q    <= '0;
            dout_q   <= '0;
        end else begin
            s1_din_q <= s1_din_d;
            s1_n1d_q <= s1_n1d_d;
            s1_c0_q  <= s1_c0_d;
            s1_c1_q  <= s1_c1_d;
            s1_de_q  <= s1_de_d;
            s2_qm_q  <= s2_qm_d;
            s2_n1q_q <= s2_n1q_d;
            s2_n0q_q <= s2_n0q_d;
            s2_c0_q  <= s2_c0_d;
            s2_c1_q  <= s2_c1_d;
            s2_de_q  <= s2_de_d;
            s3_sym_q <= s3_sym_d;
            cnt_q    <= cnt_d;
            dout_q   <= dout_d;
        end
    end

    assign dout = dout_q;

endmodule

// File: tb/tb_tmds_encoder_pipe.sv
// Self-checking bench for tmds_encoder_pipe: directed sequences plus random traffic
// compared against an in-order behavioural TMDS model with a latency queue.
module tb_tmds_encoder_pipe;

    localparam logic [9:0] TOK_00 = 10'h354;
    localparam logic [9:0] TOK_01 = 10'h0AB;
    localparam logic [9:0] TOK_10 = 10'h154;
    localparam logic [9:0] TOK_11 = 10'h2AB;

    logic       pclk = 1'b0;
    logic       reset;
    logic [7:0] din;
    logic       c0, c1, de;
    logic [9:0] dout;

    int n_checks = 0;
    int n_pass   = 0;
    int cnt_m    = 0;
    logic [9:0] exp_q[$];

    tmds_encoder_pipe dut (
        .pclk  (pclk),
        .reset (reset),
        .din   (din),
        .c0    (c0),
        .c1    (c1),
        .de    (de),
        .dout  (dout)
    );

    always #5 pclk = ~pclk;

    task automatic check(input string tag, input logic [9:0] got, input logic [9:0] exp);
        n_checks++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%03h expected 0x%03h", tag, got, exp);
    endtask

    // Encodes one pixel in stream order; the running disparity is the only state.
    function automatic logic [9:0] ref_encode(input logic [7:0] d, input logic k0,
                                              input logic k1, input logic en);
        int   ones_d, n1, n0;
        logic use_xnor, b8;
        logic [7:0] qm;
        if (!en) begin
            cnt_m = 0;
            case ({k1, k0})
                2'b00:   return TOK_00;
                2'b01:   return TOK_01;
                2'b10:   return TOK_10;
                default: return TOK_11;
            endcase
        end
        ones_d   = $countones(d);
        use_xnor = (ones_d > 4) || (ones_d == 4 && d[0] == 1'b0);
        qm[0]    = d[0];
        for (int i = 1; i < 8; i++) qm[i] = use_xnor ? (qm[i-1] == d[i]) : (qm[i-1] != d[i]);
        b8 = !use_xnor;
        n1 = $countones(qm);
        n0 = 8 - n1;
        if (cnt_m == 0 || n1 == n0) begin
            cnt_m += b8 ? (n1 - n0) : (n0 - n1);
            return {~b8, b8, b8 ? qm : ~qm};
        end
        if ((cnt_m > 0 && n1 > n0) || (cnt_m < 0 && n0 > n1)) begin
            cnt_m += (b8 ? 2 : 0) + n0 - n1;
            return {1'b1, b8, ~qm};
        end
        cnt_m += (b8 ? 0 : -2) + n1 - n0;
        return {1'b0, b8, qm};
    endfunction

    task automatic step(input logic r, input logic [7:0] d, input logic [1:0] c,
                        input logic en, input string tag);
        int         hw_cnt;
        logic [9:0] e;
        reset = r;
        din   = d;
        {c1, c0} = c;
        de    = en;
        @(posedge pclk);
        #1;
        if (r) begin
            exp_q = '{10'h000, TOK_00, TOK_00};
            cnt_m = 0;
            check({tag, "_reset"}, dout, 10'h000);
        end else begin
            exp_q.push_back(ref_encode(d, c[0], c[1], en));
            e = exp_q.pop_front();
            check(tag, dout, e);
            hw_cnt = int'(dut.cnt_q);
            check("cnt_range", {9'b0, (hw_cnt >= -10 && hw_cnt <= 10)}, 10'd1);
        end
    endtask

    initial begin
        reset = 1'b1;
        din = '0; c0 = 1'b0; c1 = 1'b0; de = 1'b0;
        for (int i = 0; i < 4; i++)
            step(1'b1, 8'($urandom), 2'($urandom), 1'($urandom), "init");
        for (int i = 0; i < 5; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "post_reset");

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'(i), 1'b0, "token");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "pad");

        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b1, "zero_run");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "pad");
        for (int i = 0; i < 4; i++) step(1'b0, 8'hFF, 2'b00, 1'b1, "ones_run");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "pad");

        step(1'b0, 8'h00, 2'b00, 1'b1, "de_gap");
        step(1'b0, 8'h00, 2'b00, 1'b1, "de_gap");
        step(1'b0, 8'h00, 2'b00, 1'b0, "de_gap");
        step(1'b0, 8'h00, 2'b00, 1'b1, "de_gap");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "pad");

        step(1'b0, 8'hA5, 2'b00, 1'b1, "mid_reset");
        step(1'b0, 8'h3C, 2'b00, 1'b1, "mid_reset");
        step(1'b1, 8'h77, 2'b11, 1'b1, "mid_reset");
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "after_mid_reset");

        for (int i = 0; i < 10000; i++) begin
            step(($urandom_range(0, 999) == 0), 8'($urandom), 2'($urandom),
                 ($urandom_range(0, 7) != 0), "random");
        end
        for (int i = 0; i < 4; i++) step(1'b0, 8'h00, 2'b00, 1'b0, "drain");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
